// File: rtl/line_pkg.sv
// Shared geometry and state encoding for the line point generator.
package line_pkg;
    localparam int X_W            = 11;
    localparam int Y_W            = 10;
    localparam int V_MAX_DFLT     = 720;
    localparam int FRAC_BITS_DFLT = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INIT   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } line_state_e;
endpackage

// File: rtl/line_round_sat.sv
// Combinational round-half-up of a fixed-point row accumulator, clamped to 0..V_MAX-1.
module line_round_sat
    import line_pkg::*;
#(
    parameter int ACC_W     = 32,
    parameter int FRAC_BITS = FRAC_BITS_DFLT,
    parameter int V_MAX     = V_MAX_DFLT
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic        [Y_W-1:0]   y_o
);
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(2 ** (FRAC_BITS - 1));
    localparam logic signed [ACC_W-1:0] TOP  = ACC_W'(V_MAX - 1);

    logic signed [ACC_W-1:0] rnd_s;

    // Round, then clamp negative rows to 0 and rows past the frame to the bottom line.
    always_comb begin
        rnd_s = (acc_i + HALF) >>> FRAC_BITS;
        if (rnd_s[ACC_W-1]) begin
            y_o = '0;
        end else if (rnd_s > TOP) begin
            y_o = Y_W'(V_MAX - 1);
        end else begin
            y_o = rnd_s[Y_W-1:0];
        end
    end
endmodule

// File: rtl/line_point_gen.sv
// Streams (x, y) points along y = a*x + b over [x_start, x_end] using a one-add DDA.
// Build option LINE_CLIP_EN: skip out-of-frame points instead of saturating them.
module line_point_gen
    import line_pkg::*;
#(
    parameter int SLOPE_W   = 16,
    parameter int FRAC_BITS = FRAC_BITS_DFLT,
    parameter int V_MAX     = V_MAX_DFLT,
    parameter int ACC_W     = 32
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [SLOPE_W-1:0] a_in,
    input  logic [Y_W-1:0]     b_in,
    input  logic [X_W-1:0]     x_start_in,
    input  logic [X_W-1:0]     x_end_in,
    input  logic               valid_in,
    output logic               ready_out,
    output logic [X_W-1:0]     x_out,
    output logic [Y_W-1:0]     y_out,
    output logic               valid_out,
    input  logic               ready_in,
    output logic               last_out,
    output logic               done_out,
    output logic               busy_out
);
    line_state_e             state_q, state_d;
    logic [SLOPE_W-1:0]      a_q, a_d;
    logic [Y_W-1:0]          b_q, b_d;
    logic [X_W-1:0]          xs_q, xs_d, xe_q, xe_d, x_cnt_q, x_cnt_d;
    logic signed [ACC_W-1:0] y_acc_q, y_acc_d;
    logic signed [ACC_W-1:0] a_ext_s, b_ext_s, x_ext_s, y_init_s;
    logic [Y_W-1:0]          y_sat_s;
    logic                    at_end_s, emit_s, last_s;

    assign a_ext_s  = ACC_W'($signed(a_q));
    assign b_ext_s  = ACC_W'(b_q);
    assign x_ext_s  = ACC_W'(xs_q);
    assign y_init_s = (b_ext_s <<< FRAC_BITS) + a_ext_s * x_ext_s;
    assign at_end_s = (x_cnt_q == xe_q);

    line_round_sat #(
        .ACC_W     (ACC_W),
        .FRAC_BITS (FRAC_BITS),
        .V_MAX     (V_MAX)
    ) u_round_sat (
        .acc_i (y_acc_q),
        .y_o   (y_sat_s)
    );

`ifdef LINE_CLIP_EN
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(2 ** (FRAC_BITS - 1));
    localparam logic signed [ACC_W-1:0] TOP  = ACC_W'(V_MAX - 1);

    function automatic logic in_rows(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] r;
        r = (v + HALF) >>> FRAC_BITS;
        return !r[ACC_W-1] && (r <= TOP);
    endfunction

    // The line is monotonic, so once the next x leaves the frame no later x returns to it.
    assign emit_s = (state_q == STREAM) && in_rows(y_acc_q);
    assign last_s = at_end_s || !in_rows(y_acc_q + a_ext_s);
`else
    assign emit_s = (state_q == STREAM);
    assign last_s = at_end_s;
`endif

    // Next-state and datapath update for the command FSM.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        xs_d    = xs_q;
        xe_d    = xe_q;
        x_cnt_d = x_cnt_q;
        y_acc_d = y_acc_q;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    xs_d    = x_start_in;
                    xe_d    = x_end_in;
                    state_d = INIT;
                end else begin
                    state_d = IDLE;
                end
            end
            INIT: begin
                if (xe_q < xs_q) begin
                    state_d = DONE;
                end else begin
                    y_acc_d = y_init_s;
                    x_cnt_d = xs_q;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (emit_s && !ready_in) begin
                    state_d = STREAM;
                end else if (emit_s ? last_s : at_end_s) begin
                    state_d = DONE;
                end else begin
                    x_cnt_d = x_cnt_q + 1'b1;
                    y_acc_d = y_acc_q + a_ext_s;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registers; reset drops any command in flight without a done pulse.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            xs_q    <= '0;
            xe_q    <= '0;
            x_cnt_q <= '0;
            y_acc_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            xs_q    <= xs_d;
            xe_q    <= xe_d;
            x_cnt_q <= x_cnt_d;
            y_acc_q <= y_acc_d;
        end
    end

    assign ready_out = (state_q == IDLE);
    assign busy_out  = (state_q != IDLE);
    assign done_out  = (state_q == DONE);
    assign valid_out = emit_s;
    assign last_out  = emit_s && last_s;
    assign x_out     = emit_s ? x_cnt_q : '0;
    assign y_out     = emit_s ? y_sat_s : '0;
endmodule

// File: tb/tb_line_point_gen.sv
// Scoreboard bench for line_point_gen: closed-form expected points queued at command issue.
module tb_line_point_gen;
    typedef struct {
        int x;
        int y;
        int last;
    } pt_t;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [15:0] a_in = '0;
    logic [9:0]  b_in = '0;
    logic [10:0] x_start_in = '0;
    logic [10:0] x_end_in = '0;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic        valid_out;
    logic        ready_in = 1'b1;
    logic        last_out;
    logic        done_out;
    logic        busy_out;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   done_cyc = 0;
    int   done_cnt = 0;
    int   pts_cmd = 0;
    bit   first_pend = 1'b0;
    bit   hold_pend = 1'b0;
    bit   bp_mode = 1'b0;
    pt_t  hold_pt;
    pt_t  e_pt;
    pt_t  exp_q[$];

    line_point_gen dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .a_in       (a_in),
        .b_in       (b_in),
        .x_start_in (x_start_in),
        .x_end_in   (x_end_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .x_out      (x_out),
        .y_out      (y_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .last_out   (last_out),
        .done_out   (done_out),
        .busy_out   (busy_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Downstream ready: held high, or toggled 1010 while backpressure is enabled.
    always @(posedge clk_in) begin
        #1;
        ready_in = bp_mode ? cyc[0] : 1'b1;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (valid_in && ready_out) begin
                acc_cyc    = cyc;
                first_pend = 1'b1;
            end
            if (hold_pend) begin
                check_eq("hold_valid", int'(valid_out), 1);
                check_eq("hold_x", int'(x_out), hold_pt.x);
                check_eq("hold_y", int'(y_out), hold_pt.y);
                check_eq("hold_last", int'(last_out), hold_pt.last);
                hold_pend = 1'b0;
            end
            if (valid_out) begin
                if (first_pend) begin
                    check_eq("first_latency", cyc - acc_cyc, 2);
                    first_pend = 1'b0;
                end
                if (ready_in) begin
                    if (exp_q.size() == 0) begin
                        check_eq("extra_point", exp_q.size(), 1);
                    end else begin
                        e_pt = exp_q.pop_front();
                        check_eq("pt_x", int'(x_out), e_pt.x);
                        check_eq("pt_y", int'(y_out), e_pt.y);
                        check_eq("pt_last", int'(last_out), e_pt.last);
                    end
                    pts_cmd++;
                end else begin
                    hold_pend    = 1'b1;
                    hold_pt.x    = int'(x_out);
                    hold_pt.y    = int'(y_out);
                    hold_pt.last = int'(last_out);
                end
            end
            if (done_out) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic send(input int a, input int b, input int xs, input int xe);
        int  k;
        int  sa;
        int  acc;
        int  r;
        pt_t p;
        @(posedge clk_in);
        #1;
        a_in       = a[15:0];
        b_in       = b[9:0];
        x_start_in = xs[10:0];
        x_end_in   = xe[10:0];
        valid_in   = 1'b1;
        pts_cmd    = 0;
        sa = a;
        if (sa > 32767) sa = sa - 65536;
        for (int x = xs; x <= xe; x++) begin
            acc    = b * 256 + sa * x;
            r      = (acc + 128) >>> 8;
            p.x    = x;
            p.y    = (r < 0) ? 0 : ((r > 719) ? 719 : r);
            p.last = (x == xe) ? 1 : 0;
            exp_q.push_back(p);
        end
        k = 0;
        @(negedge clk_in);
        while (!ready_out && k < 50) begin
            @(negedge clk_in);
            k++;
        end
        check_eq("cmd_accept", int'(ready_out), 1);
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic wait_done(input int exp_delta);
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < 300) begin
            @(posedge clk_in);
            k++;
        end
        check_eq("done_seen", done_cnt - d0, 1);
        if (exp_delta >= 0) check_eq("done_latency", done_cyc - acc_cyc, exp_delta);
        check_eq("left_points", exp_q.size(), 0);
        @(negedge clk_in);
        check_eq("ready_after_done", int'(ready_out), 1);
        check_eq("done_one_cycle", int'(done_out), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_ready"}, int'(ready_out), 1);
        check_eq({tag, "_valid"}, int'(valid_out), 0);
        check_eq({tag, "_done"}, int'(done_out), 0);
        check_eq({tag, "_busy"}, int'(busy_out), 0);
        check_eq({tag, "_last"}, int'(last_out), 0);
        check_eq({tag, "_x"}, int'(x_out), 0);
        check_eq({tag, "_y"}, int'(y_out), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int d0;
        repeat (3) @(negedge clk_in);
        check_idle_outputs("reset");
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        send(32'h0100, 10, 0, 3);          // unit slope ramp
        wait_done(6);
        send(32'hFF80, 2, 0, 6);           // -0.5 slope, rounding and low clamp
        wait_done(9);
        bp_mode = 1'b1;
        send(32'h0200, 700, 5, 15);        // backpressure with high clamp
        wait_done(-1);
        bp_mode = 1'b0;
        send(32'h0000, 100, 100, 99);      // empty range
        wait_done(2);
        check_eq("empty_points", pts_cmd, 0);
        send(32'h0000, 719, 2044, 2047);   // last column without wrap
        wait_done(6);
        send(32'h8000, 500, 0, 2);         // most negative slope
        wait_done(5);

        // Reset while the third point is presented.
        send(32'h0100, 10, 0, 9);
        k = 0;
        while (pts_cmd < 2 && k < 100) begin
            @(posedge clk_in);
            #1;
            k++;
        end
        check_eq("pre_reset_points", pts_cmd, 2);
        d0 = done_cnt;
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        exp_q.delete();
        hold_pend  = 1'b0;
        first_pend = 1'b0;
        @(negedge clk_in);
        check_idle_outputs("mid_reset");
        repeat (5) @(negedge clk_in);
        check_eq("no_done_after_reset", done_cnt - d0, 0);
        send(32'h0100, 50, 30, 33);
        wait_done(6);

        // Command presented while busy must be dropped.
        send(32'h0100, 10, 20, 25);
        @(posedge clk_in);
        #1;
        a_in       = 16'h0400;
        b_in       = 10'd3;
        x_start_in = 11'd0;
        x_end_in   = 11'd1;
        valid_in   = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        wait_done(8);
        repeat (4) @(negedge clk_in);
        check_eq("busy_ignored_idle", int'(busy_out), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
